// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in/serial-out transmitter.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bit_counter.sv
// Frame bit counter: counts emitted bits, saturates at WIDTH-1 so it never wraps.
module bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic tc_nxt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != LAST))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // tc_nxt lets the owner register a pulse that lines up with the last bit.
  assign tc     = (cnt_q == LAST);
  assign tc_nxt = (cnt_d == LAST);

endmodule

// File: rtl/piso_shift_tx.sv
// Serialises a WIDTH-bit word MSB first; pause sampled on an edge stalls the
// following cycle, so every output can come straight from a flop.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             pause,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             load_ready_q, load_ready_d;
  logic             accept, bit_now, cnt_tc, cnt_tc_nxt;

  // load_ready_q is high exactly in IDLE, so this also ignores loads mid-frame.
  assign accept  = load_valid && load_ready_q;
  // A bit leaves the register only in a cycle that actually presented it.
  assign bit_now = (state_q == SHIFT) && sout_valid_q;

  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (bit_now),
    .tc     (cnt_tc),
    .tc_nxt (cnt_tc_nxt)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shift_d = din;
        end
      end
      SHIFT: begin
        if (bit_now) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (cnt_tc) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    sout_valid_d = (state_d == SHIFT) && !pause;
    sout_d       = (state_d == SHIFT) ? shift_d[WIDTH-1] : 1'b0;
    frame_done_d = sout_valid_d && cnt_tc_nxt;
    load_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      frame_done_q <= frame_done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign frame_done = frame_done_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: WIDTH=8 and WIDTH=2 instances, frame-level model plus directed checks.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lv8 = 1'b0, p8 = 1'b0;
  logic [7:0] din8 = '0;
  logic       rdy8, so8, sv8, fd8;
  logic       lv2 = 1'b0, p2 = 1'b0;
  logic [1:0] din2 = '0;
  logic       rdy2, so2, sv2, fd2;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  logic [31:0] s8v, v8v, d8v, r8v, s2v, v2v, d2v, r2v;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .load_valid(lv8), .load_ready(rdy8), .din(din8),
    .pause(p8), .sout(so8), .sout_valid(sv8), .frame_done(fd8)
  );

  piso_shift_tx #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(rdy2), .din(din2),
    .pause(p2), .sout(so2), .sout_valid(sv2), .frame_done(fd2)
  );

  // Frame-level model: which word is in flight and which bit index is due.
  typedef struct packed {
    logic        busy;
    logic [31:0] word;
    logic [5:0]  idx;
    logic        v, s, d, r;
  } mdl_t;

  function automatic mdl_t midle();
    mdl_t n;
    n   = '0;
    n.r = 1'b1;
    return n;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int w, logic lv, logic [31:0] dw, logic p);
    mdl_t n;
    n = m;
    if (!m.busy) begin
      if (lv) begin
        n.busy = 1'b1;
        n.word = dw;
        n.idx  = '0;
      end
    end else if (m.v) begin
      n.idx = m.idx + 6'd1;
      if (int'(n.idx) == w) n.busy = 1'b0;
    end
    n.v = n.busy && !p;
    n.s = n.busy ? n.word[w - 1 - int'(n.idx)] : 1'b0;
    n.d = n.v && (int'(n.idx) == w - 1);
    n.r = !n.busy;
    return n;
  endfunction

  mdl_t m8, m2;

  always @(posedge clk or posedge rst)
    m8 <= rst ? midle() : mstep(m8, 8, lv8, {24'd0, din8}, p8);

  always @(posedge clk or posedge rst)
    m2 <= rst ? midle() : mstep(m2, 2, lv2, {30'd0, din2}, p2);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m8_sout",  {31'd0, so8},  {31'd0, m8.s});
      chk("m8_valid", {31'd0, sv8},  {31'd0, m8.v});
      chk("m8_done",  {31'd0, fd8},  {31'd0, m8.d});
      chk("m8_ready", {31'd0, rdy8}, {31'd0, m8.r});
      chk("m2_sout",  {31'd0, so2},  {31'd0, m2.s});
      chk("m2_valid", {31'd0, sv2},  {31'd0, m2.v});
      chk("m2_done",  {31'd0, fd2},  {31'd0, m2.d});
      chk("m2_ready", {31'd0, rdy2}, {31'd0, m2.r});
    end
  end

  // Records n cycles of outputs (oldest cycle in the highest bit) and applies
  // pause / load_valid changes just after the edge ending cycle c.
  task automatic rec(input int n, input int p_on, input int p_off, input int lv_off);
    s8v = '0; v8v = '0; d8v = '0; r8v = '0;
    s2v = '0; v2v = '0; d2v = '0; r2v = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      s8v = {s8v[30:0], so8}; v8v = {v8v[30:0], sv8};
      d8v = {d8v[30:0], fd8}; r8v = {r8v[30:0], rdy8};
      s2v = {s2v[30:0], so2}; v2v = {v2v[30:0], sv2};
      d2v = {d2v[30:0], fd2}; r2v = {r2v[30:0], rdy2};
      @(posedge clk); #1;
      if (c == p_on)   begin p8 = 1'b1; p2 = 1'b1; end
      if (c == p_off)  begin p8 = 1'b0; p2 = 1'b0; end
      if (c == lv_off) begin lv8 = 1'b0; lv2 = 1'b0; end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, rdy8}, 32'd1);
    chk("rst_valid", {31'd0, sv8},  32'd0);
    chk("rst_done",  {31'd0, fd8},  32'd0);
    chk("rst_sout",  {31'd0, so8},  32'd0);
    rst = 1'b0;

    // 8'hA5, no pause
    @(posedge clk); #1;
    lv8 = 1'b1; din8 = 8'hA5;
    @(posedge clk); #1;
    lv8 = 1'b0;
    rec(9, 0, 0, 0);
    chk("a5_sout",  s8v, 32'h14A);
    chk("a5_valid", v8v, 32'h1FE);
    chk("a5_done",  d8v, 32'h002);
    chk("a5_ready", r8v, 32'h001);

    // 8'hF0 with a three-cycle stall after bit 2
    lv8 = 1'b1; din8 = 8'hF0;
    @(posedge clk); #1;
    lv8 = 1'b0;
    rec(12, 1, 4, 0);
    chk("f0_valid", v8v, 32'b1100_0111_1110);
    chk("f0_sout",  s8v, 32'b1111_1110_0000);
    chk("f0_done",  d8v, 32'b0000_0000_0010);

    // 8'h3C while load_valid stays high with 8'hFF
    lv8 = 1'b1; din8 = 8'h3C;
    @(posedge clk); #1;
    din8 = 8'hFF;
    rec(18, 0, 0, 9);
    chk("3c_sout",  s8v, {14'd0, 8'h3C, 1'b0, 8'hFF, 1'b0});
    chk("3c_valid", v8v, {14'd0, 8'hFF, 1'b0, 8'hFF, 1'b0});
    chk("3c_done",  d8v, {14'd0, 8'h01, 1'b0, 8'h01, 1'b0});
    chk("3c_ready", r8v, {14'd0, 8'h00, 1'b1, 8'h00, 1'b1});

    // 8'h81 interrupted by asynchronous reset after bit 4
    lv8 = 1'b1; din8 = 8'h81;
    @(posedge clk); #1;
    lv8 = 1'b0;
    rec(4, 0, 0, 0);
    chk("81_sout",  s8v, 32'b1000);
    chk("81_valid", v8v, 32'b1111);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, sv8},  32'd0);
    chk("arst_done",  {31'd0, fd8},  32'd0);
    chk("arst_ready", {31'd0, rdy8}, 32'd1);
    chk("arst_sout",  {31'd0, so8},  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rec(10, 0, 0, 0);
    chk("post_rst_valid", v8v, 32'd0);
    chk("post_rst_done",  d8v, 32'd0);
    chk("post_rst_ready", r8v, 32'h3FF);

    // WIDTH=2: 2'b10 back-to-back
    lv2 = 1'b1; din2 = 2'b10;
    @(posedge clk); #1;
    rec(6, 0, 0, 3);
    chk("w2_valid", v2v, 32'b110110);
    chk("w2_done",  d2v, 32'b010010);
    chk("w2_sout",  s2v, 32'b100100);
    chk("w2_ready", r2v, 32'b001001);

    // WIDTH=2: pause over the last-bit cycle; pause on the idle 8-bit instance
    lv2 = 1'b1; din2 = 2'b11;
    @(posedge clk); #1;
    lv2 = 1'b0; p2 = 1'b1; p8 = 1'b1;
    rec(5, 0, 2, 0);
    chk("w2p_valid", v2v, 32'b10010);
    chk("w2p_done",  d2v, 32'b00010);
    chk("w2p_sout",  s2v, 32'b11110);
    chk("idle_pause_ready", r8v, 32'b11111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 Parameter: WIDTH, default 8, frame length in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: load_valid  input  1  parallel word offered on din.
REQ-005 Port: load_ready  output  1  block can accept a word this cycle.
REQ-006 Port: din  input  WIDTH  parallel data word to transmit.
REQ-007 Port: pause  input  1  stalls shifting while high.
REQ-008 Port: sout  output  1  serial data bit, MSB first.
REQ-009 Port: sout_valid  output  1  sout carries a new frame bit this cycle.
REQ-010 Port: frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-012 In IDLE: load_ready=1, sout_valid=0, frame_done=0, sout=0.
REQ-013 The block SHALL accept a word on the clock edge where load_valid && load_ready are both high: capture din into the shift register, clear the bit counter, and enter SHIFT.
REQ-014 load_valid while not in IDLE SHALL be ignored with no effect on state, data or counter.
REQ-015 All outputs SHALL be registered; the first bit (din[WIDTH-1]) SHALL appear on sout in the cycle after the accepting edge.
REQ-016 In SHIFT with pause=0: sout_valid=1, sout=current MSB; each edge shifts left by one with zero fill and increments the counter.
REQ-017 In SHIFT with pause=1: sout_valid=0; sout, shift register and counter hold their values; pause in IDLE has no effect.
REQ-018 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap within a frame.
REQ-019 When the counter equals WIDTH-1 and pause=0, frame_done SHALL be 1 in that cycle together with the last bit; the next edge SHALL return to IDLE.
REQ-020 An unpaused frame SHALL occupy exactly WIDTH consecutive sout_valid cycles; back-to-back frames SHALL be separated by exactly one IDLE cycle.
REQ-021 pause asserted in the last-bit cycle SHALL suppress frame_done and hold state until pause drops.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, force IDLE, clear the shift register and counter, and drive sout=0, sout_valid=0, frame_done=0, load_ready=1.
REQ-023 Reset mid-frame SHALL discard the partial frame; no frame_done SHALL be emitted for it.
REQ-024 After rst falls, the first acceptance SHALL occur no earlier than the first rising clk edge.

Structure
REQ-025 A shared package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and the default WIDTH constant.
REQ-026 The bit counter SHALL be a sub-module, bit_counter, with clear, enable, and a terminal-count output at WIDTH-1.
REQ-027 The shift register and FSM SHALL remain in piso_shift_tx.

Verification
REQ-028 WIDTH=8, load 8'hA5, pause=0 -> sout over 8 valid cycles = 1,0,1,0,0,1,0,1; frame_done high only in cycle 8; load_ready low during cycles 1-8.
REQ-029 Load 8'hF0, pause high for 3 cycles after bit 2 -> sout_valid low 3 cycles with sout held at 1; then bits 3-8 = 1,1,0,0,0,0; total 11 cycles.
REQ-030 Load 8'h3C, hold load_valid high with din=8'hFF during the frame -> 8'h3C is sent unchanged; 8'hFF is accepted in the IDLE cycle after frame_done and sent as 8 ones.
REQ-031 Load 8'h81, assert rst asynchronously mid-cycle after bit 4 -> outputs cleared before the next edge, no frame_done, load_ready=1.
REQ-032 WIDTH=2, load 2'b10 twice back-to-back -> sout_valid pattern 1,1,0,1,1; frame_done in cycles 2 and 5.
